// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - ready/valid pipeline stage with 2-entry skid buffer, flush and bubble-zeroed control
module pipe_stage_skid #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [1:0]            occupancy_o
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;

    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = valid_i & ready_o;
    assign xfer_out = valid_o & ready_i;

    // Every path into EMPTY clears main_ctrl so ctrl_o is zero on bubbles;
    // payload registers are left alone on flush and drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush_i) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        main_data <= data_i;
                        main_ctrl <= ctrl_i;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_data <= data_i;
                        main_ctrl <= ctrl_i;
                    end else if (xfer_in) begin
                        skid_data <= data_i;
                        skid_ctrl <= ctrl_i;
                        state     <= ST_FULL;
                    end else if (xfer_out) begin
                        main_ctrl <= '0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        skid_ctrl <= '0;
                        state     <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    main_ctrl <= '0;
                    skid_ctrl <= '0;
                end
            endcase
        end
    end

    // Handshake outputs decode only the state register, so ready_i never reaches ready_o.
    assign ready_o     = (state != ST_FULL);
    assign valid_o     = (state != ST_EMPTY);
    assign occupancy_o = state;
    assign data_o      = main_data;
    assign ctrl_o      = main_ctrl;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - table-driven self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [63:0] data_in = '0;
    logic [15:0] ctrl_in = '0;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [63:0] data_out;
    logic [15:0] ctrl_out;
    logic [1:0]  occ;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(.DATA_WIDTH(64), .CTRL_WIDTH(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .valid_i     (valid_in),
        .ready_o     (ready_out),
        .data_i      (data_in),
        .ctrl_i      (ctrl_in),
        .valid_o     (valid_out),
        .ready_i     (ready_in),
        .data_o      (data_out),
        .ctrl_o      (ctrl_out),
        .occupancy_o (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        vin;
        logic [63:0] din;
        logic [15:0] cin;
        logic        rin;
        logic        ev;
        logic        er;
        logic [1:0]  eocc;
        logic [63:0] ed;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic vi, input logic [63:0] di,
                       input logic [15:0] ci, input logic ri, input logic ev, input logic er,
                       input logic [1:0] eo, input logic [63:0] ed, input logic [15:0] ec);
        vec_t v;
        v.rst = r; v.flush = f; v.vin = vi; v.din = di; v.cin = ci; v.rin = ri;
        v.ev = ev; v.er = er; v.eocc = eo; v.ed = ed; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic vi, input logic [63:0] di,
                         input logic [15:0] ci, input logic ri);
        rst = r; flush = f; valid_in = vi; data_in = di; ctrl_in = ci; ready_in = ri;
    endtask

    logic [79:0] sb[$];
    logic [79:0] head;
    logic        do_in;
    logic        do_out;
    int          drain_cycles;

    initial begin
        // reset
        add(1,0,0,64'h0,16'h0,0,   0,1,0,64'h0,16'h0);
        // streaming 1..8, then drain
        for (int k = 1; k <= 8; k++)
            add(0,0,1,64'(k),16'(16'h0010 + k),1,   1,1,1,64'(k),16'(16'h0010 + k));
        add(0,0,0,64'h0,16'h0,1,   0,1,0,64'h8,16'h0);
        // stall/skid: A, B, C with one stall cycle while A at output
        add(0,0,1,64'hA,16'h0A01,1,   1,1,1,64'hA,16'h0A01);
        add(0,0,1,64'hB,16'h0B02,0,   1,0,2,64'hA,16'h0A01);
        add(0,0,1,64'hC,16'h0C03,1,   1,1,1,64'hB,16'h0B02);
        add(0,0,1,64'hC,16'h0C03,1,   1,1,1,64'hC,16'h0C03);
        add(0,0,0,64'h0,16'h0,1,      0,1,0,64'hC,16'h0);
        // flush in FULL with an input presented
        add(0,0,1,64'h11,16'hFFFF,0,  1,1,1,64'h11,16'hFFFF);
        add(0,0,1,64'h22,16'h00AA,0,  1,0,2,64'h11,16'hFFFF);
        add(0,1,1,64'h1234,16'h1234,0, 0,1,0,64'h11,16'h0);
        add(0,0,0,64'h0,16'h0,1,      0,1,0,64'h11,16'h0);
        // flush in EMPTY drops an input even though ready is high
        add(0,1,1,64'hDD,16'h00DD,1,  0,1,0,64'h11,16'h0);
        // flush in ONE with downstream ready: head consumed, not replayed
        add(0,0,1,64'h5A,16'h005A,0,  1,1,1,64'h5A,16'h005A);
        add(0,1,1,64'h5B,16'h005B,1,  0,1,0,64'h5A,16'h0);
        // drain to bubble keeps data
        add(0,0,1,64'h77,16'hBEEF,0,  1,1,1,64'h77,16'hBEEF);
        add(0,0,0,64'h0,16'h0,1,      0,1,0,64'h77,16'h0);
        // reset beats flush in FULL
        add(0,0,1,64'h55,16'h0055,0,  1,1,1,64'h55,16'h0055);
        add(0,0,1,64'h66,16'h0066,0,  1,0,2,64'h55,16'h0055);
        add(1,1,1,64'h99,16'h0099,0,  0,1,0,64'h0,16'h0);
        add(0,0,1,64'h44,16'h0044,1,  1,1,1,64'h44,16'h0044);
        add(0,0,0,64'h0,16'h0,1,      0,1,0,64'h44,16'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].din, vecs[i].cin, vecs[i].rin);
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i), 64'(valid_out), 64'(vecs[i].ev));
            check($sformatf("v%0d ready", i), 64'(ready_out), 64'(vecs[i].er));
            check($sformatf("v%0d occ", i),   64'(occ),       64'(vecs[i].eocc));
            check($sformatf("v%0d data", i),  data_out,       vecs[i].ed);
            check($sformatf("v%0d ctrl", i),  64'(ctrl_out),  64'(vecs[i].ec));
        end

        // Inputs changed mid-cycle must not move outputs while FULL.
        drive(0,0,1,64'hE1,16'h00E1,0);
        @(posedge clk); #1;
        drive(0,0,1,64'hE2,16'h00E2,0);
        @(posedge clk); #1;
        check("full occ", 64'(occ), 64'd2);
        drive(0,1,1,64'hE3,16'h00E3,1);
        #2;
        check("comb ready", 64'(ready_out), 64'd0);
        check("comb valid", 64'(valid_out), 64'd1);
        check("comb occ",   64'(occ),       64'd2);
        @(posedge clk); #1;
        check("flush full valid", 64'(valid_out), 64'd0);
        check("flush full ctrl",  64'(ctrl_out),  64'd0);
        check("flush full data",  data_out,       64'hE1);

        // Scoreboarded random traffic: FIFO order, no loss, occupancy tracking.
        drive(0,0,0,64'h0,16'h0,0);
        for (int c = 0; c < 300; c++) begin
            drive(0, 0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 16'($urandom),
                  1'($urandom_range(0, 3) != 0));
            #1;
            do_in  = valid_in & ready_out;
            do_out = valid_out & ready_in;
            if (valid_out) begin
                if (sb.size() == 0) begin
                    check("sb underflow", 64'(sb.size()), 64'd1);
                end else begin
                    head = sb[0];
                    check($sformatf("sb data c%0d", c), data_out, head[79:16]);
                    check($sformatf("sb ctrl c%0d", c), 64'(ctrl_out), 64'(head[15:0]));
                end
            end else begin
                check($sformatf("bubble ctrl c%0d", c), 64'(ctrl_out), 64'd0);
            end
            if (do_out && sb.size() > 0) void'(sb.pop_front());
            if (do_in) sb.push_back({data_in, ctrl_in});
            @(posedge clk); #1;
            check($sformatf("sb occ c%0d", c),   64'(occ),       64'(sb.size()));
            check($sformatf("sb ready c%0d", c), 64'(ready_out), 64'(sb.size() < 2));
        end

        // Bounded drain of whatever remains.
        drive(0,0,0,64'h0,16'h0,1);
        drain_cycles = 0;
        while (valid_out && drain_cycles < 10) begin
            if (sb.size() > 0) begin
                head = sb.pop_front();
                check("drain data", data_out, head[79:16]);
            end
            @(posedge clk); #1;
            drain_cycles++;
        end
        check("drain timeout", 64'(valid_out), 64'd0);
        check("drain empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
